dummy_hls_ip_job_dispatcher: RTL and testbench

//  Initiator/master end of the HWPE peripheral control port: drives hwpe_ctrl_intf_periph.master into a dummy_hls_ip control slave.

---
 rtl/dummy_hls_ip_package.sv | 31 +++
 rtl/dummy_hls_ip_periph_master.sv | 79 +++++++
 rtl/dummy_hls_ip_job_dispatcher.sv | 197 +++++++++++++++++++
 tb/tb_dummy_hls_ip_job_dispatcher.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dummy_hls_ip_package.sv
// rtl/dummy_hls_ip_package.sv - register map, dispatcher state and descriptor types for the dummy_hls_ip job dispatcher
package dummy_hls_ip_package;

    localparam logic [31:0] HWPE_REG_TRIGGER    = 32'h0000_0000;
    localparam logic [31:0] HWPE_REG_ACQUIRE    = 32'h0000_0004;
    localparam logic [31:0] HWPE_REG_STATUS     = 32'h0000_000C;
    localparam logic [31:0] HWPE_REG_SOFT_CLEAR = 32'h0000_0014;
    localparam logic [31:0] HWPE_REG_JOB_BASE   = 32'h0000_0040;

    localparam int JOB_REGS_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE,
        ACQ,
        BACKOFF,
        WR,
        TRIG,
        WAIT,
        ABORT,
        DONE
    } dispatch_state_t;

    typedef struct packed {
        logic [JOB_REGS_DEFAULT-1:0][31:0] regs;
    } job_desc_t;

    function automatic logic [31:0] job_reg_addr(input logic [7:0] idx);
        return HWPE_REG_JOB_BASE + {22'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/dummy_hls_ip_periph_master.sv
// rtl/dummy_hls_ip_periph_master.sv - single-outstanding request engine for the HWPE peripheral control port
module dummy_hls_ip_periph_master #(
    parameter int ID_WIDTH = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wen,
    input  logic [31:0]         cmd_add,
    input  logic [31:0]         cmd_data,
    output logic                rsp_valid,
    output logic [31:0]         rsp_data,
    output logic                periph_req,
    output logic [31:0]         periph_add,
    output logic                periph_wen,
    output logic [3:0]          periph_be,
    output logic [31:0]         periph_data,
    output logic [ID_WIDTH-1:0] periph_id,
    input  logic                periph_gnt,
    input  logic [31:0]         periph_r_data,
    input  logic                periph_r_valid,
    input  logic [ID_WIDTH-1:0] periph_r_id
);

    logic        req_q;
    logic        rd_wait_q;
    logic        wen_q;
    logic [31:0] add_q;
    logic [31:0] data_q;
    logic [3:0]  be_q;
    logic        r_match;

    // Only responses tagged with our constant id close a read.
    assign r_match   = periph_r_valid && (periph_r_id == '0);
    assign cmd_ready = !req_q && !rd_wait_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q     <= 1'b0;
            rd_wait_q <= 1'b0;
            wen_q     <= 1'b1;
            add_q     <= '0;
            data_q    <= '0;
            be_q      <= '0;
        end else if (clear_i) begin
            req_q     <= 1'b0;
            rd_wait_q <= 1'b0;
            wen_q     <= 1'b1;
            add_q     <= '0;
            data_q    <= '0;
            be_q      <= '0;
        end else if (cmd_valid && cmd_ready) begin
            req_q  <= 1'b1;
            wen_q  <= cmd_wen;
            add_q  <= cmd_add;
            data_q <= cmd_data;
            be_q   <= 4'hF;
        end else if (req_q && periph_gnt) begin
            req_q     <= 1'b0;
            rd_wait_q <= wen_q;
        end else if (rd_wait_q && r_match) begin
            rd_wait_q <= 1'b0;
        end
    end

    // A grant or read beat racing a clear belongs to an abandoned transfer.
    assign rsp_valid = !clear_i && ((req_q && periph_gnt && !wen_q) || (rd_wait_q && r_match));
    assign rsp_data  = periph_r_data;

    assign periph_req  = req_q && !clear_i;
    assign periph_add  = add_q;
    assign periph_wen  = wen_q;
    assign periph_be   = be_q;
    assign periph_data = data_q;
    assign periph_id   = '0;

endmodule

// File: rtl/dummy_hls_ip_job_dispatcher.sv
// rtl/dummy_hls_ip_job_dispatcher.sv - runs one dummy_hls_ip offload per descriptor; DISPATCH_TIMEOUT_EN adds a WAIT timeout with soft-clear abort
module dummy_hls_ip_job_dispatcher
    import dummy_hls_ip_package::*;
#(
    parameter int N_JOB_REGS  = 4,
    parameter int ID_WIDTH    = 10,
    parameter int RETRY_GAP   = 8,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    job_valid_i,
    output logic                    job_ready_o,
    input  logic [N_JOB_REGS*32-1:0] job_regs_i,
    input  logic                    evt_i,
    output logic                    done_o,
    output logic [7:0]              done_id_o,
    output logic                    err_o,
    output logic                    busy_o,
    output logic                    periph_req,
    output logic [31:0]             periph_add,
    output logic                    periph_wen,
    output logic [3:0]              periph_be,
    output logic [31:0]             periph_data,
    output logic [ID_WIDTH-1:0]     periph_id,
    input  logic                    periph_gnt,
    input  logic [31:0]             periph_r_data,
    input  logic                    periph_r_valid,
    input  logic [ID_WIDTH-1:0]     periph_r_id
);

    localparam int IDX_W = $clog2(N_JOB_REGS) + 1;
    localparam int SEL_W = $clog2(N_JOB_REGS);
    localparam int GAP_W = $clog2(RETRY_GAP + 1);

    dispatch_state_t               state_q;
    logic [N_JOB_REGS-1:0][31:0]   regs_q;
    logic [IDX_W-1:0]              idx_q;
    logic [7:0]                    id_q;
    logic [GAP_W-1:0]              gap_q;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wen;
    logic [31:0] cmd_add;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        unused_rsp_bits;

    assign unused_rsp_bits = ^{rsp_data[30:8], cmd_ready};

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    // Bus states hold cmd_valid; the engine refuses new commands until the previous one responds.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_wen   = 1'b1;
        cmd_add   = '0;
        cmd_data  = '0;
        case (state_q)
            ACQ: begin
                cmd_valid = 1'b1;
                cmd_add   = HWPE_REG_ACQUIRE;
            end
            WR: begin
                cmd_valid = 1'b1;
                cmd_wen   = 1'b0;
                cmd_add   = job_reg_addr(8'(idx_q));
                cmd_data  = regs_q[idx_q[SEL_W-1:0]];
            end
            TRIG: begin
                cmd_valid = 1'b1;
                cmd_wen   = 1'b0;
                cmd_add   = HWPE_REG_TRIGGER;
            end
`ifdef DISPATCH_TIMEOUT_EN
            ABORT: begin
                cmd_valid = 1'b1;
                cmd_wen   = 1'b0;
                cmd_add   = HWPE_REG_SOFT_CLEAR;
                cmd_data  = 32'd1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            regs_q  <= '0;
            idx_q   <= '0;
            id_q    <= '0;
            gap_q   <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else if (clear_i) begin
            state_q <= IDLE;
`ifdef DISPATCH_TIMEOUT_EN
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (job_valid_i) begin
                    regs_q  <= job_regs_i;
                    state_q <= ACQ;
`ifdef DISPATCH_TIMEOUT_EN
                    err_q   <= 1'b0;
`endif
                end
                ACQ: if (rsp_valid) begin
                    if (rsp_data[31]) begin
                        gap_q   <= '0;
                        state_q <= BACKOFF;
                    end else begin
                        id_q    <= rsp_data[7:0];
                        idx_q   <= '0;
                        state_q <= WR;
                    end
                end
                BACKOFF: begin
                    if (gap_q == GAP_W'(RETRY_GAP - 1)) state_q <= ACQ;
                    else                                gap_q   <= gap_q + 1'b1;
                end
                WR: if (rsp_valid) begin
                    if (idx_q == IDX_W'(N_JOB_REGS - 1)) state_q <= TRIG;
                    else                                 idx_q   <= idx_q + 1'b1;
                end
                TRIG: if (rsp_valid) begin
                    state_q <= WAIT;
`ifdef DISPATCH_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                WAIT: begin
                    if (evt_i) state_q <= DONE;
`ifdef DISPATCH_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) state_q <= ABORT;
                    else tmo_q <= tmo_q + 1'b1;
`endif
                end
`ifdef DISPATCH_TIMEOUT_EN
                ABORT: if (rsp_valid) begin
                    err_q   <= 1'b1;
                    state_q <= DONE;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign job_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign done_id_o   = done_o ? id_q : 8'd0;
`ifdef DISPATCH_TIMEOUT_EN
    assign err_o       = done_o && err_q;
`else
    assign err_o       = 1'b0;
`endif

    dummy_hls_ip_periph_master #(
        .ID_WIDTH (ID_WIDTH)
    ) u_periph_master (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_wen        (cmd_wen),
        .cmd_add        (cmd_add),
        .cmd_data       (cmd_data),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .periph_req     (periph_req),
        .periph_add     (periph_add),
        .periph_wen     (periph_wen),
        .periph_be      (periph_be),
        .periph_data    (periph_data),
        .periph_id      (periph_id),
        .periph_gnt     (periph_gnt),
        .periph_r_data  (periph_r_data),
        .periph_r_valid (periph_r_valid),
        .periph_r_id    (periph_r_id)
    );

endmodule

// File: tb/tb_dummy_hls_ip_job_dispatcher.sv
// tb/tb_dummy_hls_ip_job_dispatcher.sv - randomized offload jobs against a slave model and expected access sequences
module tb_dummy_hls_ip_job_dispatcher;

    localparam int NR  = 4;
    localparam int GAP = 8;
    localparam int TMO = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            clear = 1'b0;
    logic            job_valid = 1'b0;
    logic [NR*32-1:0] job_regs = '0;
    logic            evt = 1'b0;
    logic            job_ready, done, err, busy;
    logic [7:0]      done_id;
    logic            req, wen;
    logic [31:0]     add, data;
    logic [3:0]      be;
    logic [9:0]      id;
    logic            gnt = 1'b0;
    logic            r_valid = 1'b0;
    logic [31:0]     r_data = '0;
    logic [9:0]      r_id = '0;

    always #5 clk = ~clk;

    dummy_hls_ip_job_dispatcher #(
        .N_JOB_REGS (NR), .ID_WIDTH (10), .RETRY_GAP (GAP), .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i (clk), .rst_ni (rst_n), .clear_i (clear),
        .job_valid_i (job_valid), .job_ready_o (job_ready), .job_regs_i (job_regs),
        .evt_i (evt), .done_o (done), .done_id_o (done_id), .err_o (err), .busy_o (busy),
        .periph_req (req), .periph_add (add), .periph_wen (wen), .periph_be (be),
        .periph_data (data), .periph_id (id), .periph_gnt (gnt),
        .periph_r_data (r_data), .periph_r_valid (r_valid), .periph_r_id (r_id)
    );

    typedef struct {
        logic [31:0] add;
        logic        wen;
        logic [31:0] data;
    } acc_t;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    acc_t        log_q[$], exp_q[$];
    logic [31:0] acq_q[$];
    int          gmax = 0, gdelay = 0, evt_d = 1, trig_cyc = 0, exp_done_cyc = -1;
    int          rd_wait = 0, last_busy_cyc = -1, done_cnt = 0, done_cyc = 0;
    bit          gnt_block = 0, spur_en = 0, in_wait = 0, rd_pend = 0, exp_err = 0;
    logic [31:0] rd_val = '0;
    logic [7:0]  exp_id = '0, last_done_id = '0;
    logic        last_err = 1'b0;
    logic        prev_req = 1'b0, prev_wen = 1'b1, prev_gnt = 1'b0;
    logic [31:0] prev_add = '0, prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle checker, slave model and event generator.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            check("ready_vs_busy", job_ready, !busy);
            if (req) begin
                check("be", be, 4'hF);
                check("id", id, 0);
            end
            if (prev_req && !prev_gnt && !clear) begin
                check("req_held", req, 1);
                check("add_held", add, prev_add);
                check("wen_held", wen, prev_wen);
                check("data_held", data, prev_data);
            end
            check("done_timing", done, cyc == exp_done_cyc);
            check("err", err, done && exp_err);
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                last_done_id = done_id;
                last_err     = err;
                check("done_id", done_id, exp_id);
            end
            if (req && !prev_req && wen && add == 32'h4 && last_busy_cyc >= 0) begin
                check("retry_gap", (cyc - last_busy_cyc) > GAP, 1);
                last_busy_cyc = -1;
            end
        end
        prev_req = req; prev_add = add; prev_wen = wen; prev_data = data;

        gnt = 1'b0; r_valid = 1'b0; r_id = '0;
        if (rd_pend) begin
            if (rd_wait == 0) begin
                r_valid = 1'b1; r_data = rd_val; rd_pend = 0;
                if (rd_val[31]) last_busy_cyc = cyc;
            end else begin
                rd_wait--;
                if ($urandom_range(0, 3) == 0) begin
                    r_valid = 1'b1; r_id = 10'd5; r_data = 32'h8000_00AA;
                end
            end
        end
        if (req && !gnt_block) begin
            if (gdelay == 0) begin
                gnt = 1'b1;
                log_q.push_back('{add, wen, data});
                gdelay = $urandom_range(0, gmax);
                if (wen) begin
                    rd_pend = 1; rd_wait = $urandom_range(0, 2);
                    rd_val  = (acq_q.size() > 0) ? acq_q.pop_front() : 32'h0;
                end else if (add == 32'h0) begin
                    in_wait = 1; trig_cyc = cyc;
                end else if (add == 32'h14) begin
                    in_wait = 0; exp_done_cyc = cyc + 1;
                end
            end else begin
                gdelay--;
            end
        end

        evt = 1'b0;
        if (in_wait && trig_cyc != cyc) begin
            if (evt_d > 0 && cyc == trig_cyc + evt_d) begin
                evt = 1'b1; exp_done_cyc = cyc + 1; in_wait = 0;
            end
        end else if (spur_en) begin
            evt = ($urandom_range(0, 3) == 0);
        end
        prev_gnt = gnt;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic start_job(input logic [NR*32-1:0] regs, input int n_busy, input logic [7:0] aid,
                             input int d, input int gm, input bit spur);
        acq_q.delete(); exp_q.delete(); log_q.delete();
        for (int i = 0; i < n_busy; i++) begin
            acq_q.push_back(32'h8000_0000 | $urandom);
            exp_q.push_back('{32'h4, 1'b1, 32'h0});
        end
        acq_q.push_back({1'b0, 23'($urandom), aid});
        exp_q.push_back('{32'h4, 1'b1, 32'h0});
        for (int i = 0; i < NR; i++) exp_q.push_back('{32'h40 + 32'(4 * i), 1'b0, regs[i*32 +: 32]});
        exp_q.push_back('{32'h0, 1'b0, 32'h0});
        if (d == 0) exp_q.push_back('{32'h14, 1'b0, 32'h1});
        exp_id = aid; exp_err = (d == 0);
        gmax = gm; spur_en = spur; evt_d = d; done_cnt = 0;
        for (int t = 0; t < 100 && !job_ready; t++) tick();
        check("accept_ready", job_ready, 1);
        job_regs = regs; job_valid = 1'b1;
        tick();
        job_regs = {$urandom, $urandom, $urandom, $urandom};
        repeat ($urandom_range(0, 3)) tick();
        job_valid = 1'b0;
    endtask

    task automatic finish_job(input string tag);
        for (int t = 0; t < 3000 && done_cnt == 0; t++) tick();
        repeat (3) tick();
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_idle"}, job_ready, 1);
        check({tag, "_n_access"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check({tag, "_add"}, log_q[i].add, exp_q[i].add);
            check({tag, "_wen"}, log_q[i].wen, exp_q[i].wen);
            if (!exp_q[i].wen) check({tag, "_data"}, log_q[i].data, exp_q[i].data);
        end
    endtask

    initial begin
        int n_acq;
        repeat (2) @(negedge clk);
        check("rst_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_done_id", done_id, 0);
        check("rst_err", err, 0);
        check("rst_req", req, 0);
        check("rst_wen", wen, 1);
        check("rst_add", add, 0);
        check("rst_data", data, 0);
        check("rst_be", be, 0);
        check("rst_id", id, 0);
        #1 rst_n = 1'b1;
        tick();

        start_job({32'd1, 32'd16, 32'd16, 32'd7}, 0, 8'd3, 20, 0, 0);
        finish_job("basic");
        check("basic_id_lit", last_done_id, 8'd3);
        check("basic_n_lit", log_q.size(), 6);
        check("basic_first_wr_add", log_q[1].add, 32'h40);
        check("basic_first_wr_data", log_q[1].data, 32'd7);
        check("basic_last_wr_add", log_q[4].add, 32'h4C);
        check("basic_trig_add", log_q[5].add, 32'h0);
        check("basic_latency", done_cyc - trig_cyc, 21);

        start_job({$urandom, $urandom, $urandom, $urandom}, 2, 8'd0, 5, 0, 0);
        finish_job("busy");
        n_acq = 0;
        foreach (log_q[i]) if (log_q[i].add == 32'h4) n_acq++;
        check("busy_acq_reads", n_acq, 3);
        check("busy_id_lit", last_done_id, 8'd0);

        for (int j = 0; j < 20; j++) begin
            start_job({$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 2),
                      8'($urandom), $urandom_range(1, 30), $urandom_range(0, 5), 1);
            finish_job("rand");
        end

        start_job({$urandom, $urandom, $urandom, $urandom}, 0, 8'h5A, 10, 0, 1);
        for (int t = 0; t < 200 && log_q.size() < 3; t++) tick();
        gnt_block = 1;
        repeat (3) tick();
        check("clr_pre_req", req, 1);
        clear = 1'b1;
        @(negedge clk);
        check("clr_req", req, 0);
        check("clr_ready", job_ready, 1);
        check("clr_busy", busy, 0);
        #1 clear = 1'b0;
        gnt_block = 0; gdelay = 0; rd_pend = 0; in_wait = 0;
        tick();
        check("clr_no_done", done_cnt, 0);
        start_job({$urandom, $urandom, $urandom, $urandom}, 0, 8'h21, 7, 2, 1);
        finish_job("after_clr");

`ifdef DISPATCH_TIMEOUT_EN
        start_job({$urandom, $urandom, $urandom, $urandom}, 0, 8'h33, 0, 0, 0);
        finish_job("timeout");
        check("timeout_err_lit", last_err, 1);
        check("timeout_soft_clear", log_q[log_q.size() - 1].add, 32'h14);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
